// File: rtl/operand_packer.sv
// Serial-to-packed operand front end for the adder-tree path: packs INPUT_NUM operands
// into one zero-padded vector. Optional HOLD stall counter under OPERAND_PACKER_STALL_CNT_EN.
module operand_packer #(
    parameter int WIDTH     = 32,
    parameter int INPUT_NUM = 4,
    parameter int CNT_W     = $clog2(INPUT_NUM + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [WIDTH-1:0]                    in_data,
    input  logic                                in_valid,
    input  logic                                in_last,
    output logic                                in_ready,
    output logic [INPUT_NUM-1:0][WIDTH-1:0]     out_data,
    output logic [CNT_W-1:0]                    out_lanes,
    output logic                                out_valid,
    input  logic                                out_ready
`ifdef OPERAND_PACKER_STALL_CNT_EN
    ,
    output logic [31:0]                         stall_cnt
`endif
);

    localparam int IDX_W = $clog2(INPUT_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_NUM - 1);

    typedef enum logic {
        S_FILL,
        S_HOLD
    } state_t;

    state_t                          r_state;
    state_t                          w_next_state;
    logic [INPUT_NUM-1:0][WIDTH-1:0] r_fill;
    logic [IDX_W-1:0]                r_idx;
    logic [INPUT_NUM-1:0][WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0]                r_out_lanes;
    logic                            r_out_valid;

    logic                            w_accept;
    logic                            w_complete;
    logic                            w_slot_free;
    logic                            w_load;
    logic [INPUT_NUM-1:0][WIDTH-1:0] w_load_vec;

    assign in_ready    = (r_state == S_FILL);
    assign w_accept    = in_valid && in_ready;
    assign w_complete  = w_accept && ((r_idx == LAST_IDX) || in_last);
    assign w_slot_free = !r_out_valid || out_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_vec   = r_fill;
        case (r_state)
            S_FILL: begin
                if (w_complete) begin
                    if (w_slot_free) begin
                        w_load            = 1'b1;
                        w_load_vec[r_idx] = in_data;
                    end else begin
                        w_next_state = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_load       = 1'b1;
                    w_next_state = S_FILL;
                end
            end
            default: w_next_state = S_FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Lanes above idx stay zero because the buffer is cleared on every load; that is the padding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill <= '0;
            r_idx  <= '0;
        end else if (w_load) begin
            r_fill <= '0;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_fill[r_idx] <= in_data;
            if (!w_complete) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_data  <= '0;
            r_out_lanes <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_load_vec;
            r_out_lanes <= CNT_W'(r_idx) + CNT_W'(1);
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_lanes = r_out_lanes;
    assign out_valid = r_out_valid;

`ifdef OPERAND_PACKER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_HOLD) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_operand_packer.sv
// Directed self-checking bench for operand_packer (WIDTH=32, INPUT_NUM=4).
module tb_operand_packer;

    localparam int WIDTH     = 32;
    localparam int INPUT_NUM = 4;
    localparam int CNT_W     = $clog2(INPUT_NUM + 1);

    logic                            clk;
    logic                            rst;
    logic [WIDTH-1:0]                in_data;
    logic                            in_valid;
    logic                            in_last;
    logic                            in_ready;
    logic [INPUT_NUM-1:0][WIDTH-1:0] out_data;
    logic [CNT_W-1:0]                out_lanes;
    logic                            out_valid;
    logic                            out_ready;
`ifdef OPERAND_PACKER_STALL_CNT_EN
    logic [31:0]                     stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    operand_packer #(
        .WIDTH(WIDTH),
        .INPUT_NUM(INPUT_NUM)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_lanes(out_lanes),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef OPERAND_PACKER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Lane 0 is the first argument.
    function automatic logic [127:0] vec(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Offer one word for exactly one edge; caller is positioned at posedge+1.
    task automatic push(input logic [31:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(2);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_out_lanes", 128'(out_lanes), 128'(0));
        rst = 1'b1;
        idle(1);
        check("rst_in_ready", 128'(in_ready), 128'(1));

        // Full group 1..4
        push(1, 0); push(2, 0); push(3, 0);
        check("g1_not_yet", 128'(out_valid), 128'(0));
        push(4, 0);
        check("g1_valid", 128'(out_valid), 128'(1));
        check("g1_data", out_data, vec(1, 2, 3, 4));
        check("g1_lanes", 128'(out_lanes), 128'(4));
        check("g1_in_ready", 128'(in_ready), 128'(1));

        // Back-to-back groups 10..17
        for (int i = 10; i < 18; i++) begin
            check("b2b_in_ready", 128'(in_ready), 128'(1));
            push(32'(i), 0);
            if (i == 13) begin
                check("b2b_v1_data", out_data, vec(10, 11, 12, 13));
                check("b2b_v1_valid", 128'(out_valid), 128'(1));
            end
            if (i == 14) check("b2b_drained", 128'(out_valid), 128'(0));
        end
        check("b2b_v2_data", out_data, vec(14, 15, 16, 17));
        check("b2b_v2_lanes", 128'(out_lanes), 128'(4));

        // Early close, then single-word group concurrent with transfer
        push(5, 0);
        push(6, 1);
        check("last2_data", out_data, vec(5, 6, 0, 0));
        check("last2_lanes", 128'(out_lanes), 128'(2));
        push(20, 1);
        check("single_valid", 128'(out_valid), 128'(1));
        check("single_data", out_data, vec(20, 0, 0, 0));
        check("single_lanes", 128'(out_lanes), 128'(1));
        idle(1);
        check("single_drained", 128'(out_valid), 128'(0));

        // Backpressure into HOLD
        out_ready = 1'b0;
        for (int i = 30; i < 38; i++) begin
            check("bp_in_ready", 128'(in_ready), 128'(1));
            push(32'(i), 0);
        end
        check("hold_in_ready", 128'(in_ready), 128'(0));
        check("hold_v1_stable", out_data, vec(30, 31, 32, 33));
        in_valid = 1'b1;
        in_data  = 32'd99;
        idle(3);
        in_valid = 1'b0;
        check("hold_still", 128'(in_ready), 128'(0));
        check("hold_v1_held", out_data, vec(30, 31, 32, 33));
        check("hold_v1_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("hold_v2_valid", 128'(out_valid), 128'(1));
        check("hold_v2_data", out_data, vec(34, 35, 36, 37));
        check("hold_v2_lanes", 128'(out_lanes), 128'(4));
        check("hold_exit_ready", 128'(in_ready), 128'(1));
`ifdef OPERAND_PACKER_STALL_CNT_EN
        check("stall_cnt", 128'(stall_cnt), 128'(4));
`endif
        idle(1);
        check("hold_v2_stable", out_data, vec(34, 35, 36, 37));
        out_ready = 1'b1;
        idle(1);
        check("hold_v2_drained", 128'(out_valid), 128'(0));

        // in_last on the final lane behaves like natural completion
        push(60, 0); push(61, 0); push(62, 0); push(63, 1);
        check("last_lane3_data", out_data, vec(60, 61, 62, 63));
        check("last_lane3_lanes", 128'(out_lanes), 128'(4));
        push(40, 1);
        check("no_stale_99", out_data, vec(40, 0, 0, 0));

        // Reset with a pending vector and a partial group
        out_ready = 1'b0;
        push(50, 0); push(51, 0); push(52, 0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_data", out_data, 128'(0));
        check("mid_rst_lanes", 128'(out_lanes), 128'(0));
        idle(1);
        rst = 1'b1;
        out_ready = 1'b1;
        idle(1);
        push(7, 0); push(8, 0); push(9, 0); push(10, 0);
        check("post_rst_data", out_data, vec(7, 8, 9, 10));
        check("post_rst_lanes", 128'(out_lanes), 128'(4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
